apb_reg_slave: RTL and testbench

APB_REG_SLAVE -- requirements
Module: apb_reg_slave

---
 rtl/apb_reg_slave.sv | 167 ++++++++++++++++
 tb/tb_apb_reg_slave.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/apb_reg_slave.sv
// APB register slave: NUM_REGS word registers, register 0 is a read-only ID.
// Configurable access-phase wait states; errors flagged on PSLVERR.
// Optional feature macro: APB_SLV_PROT_EN. When it is defined, unprivileged
// accesses (PPROT[0]=0) to the upper half of the register map are rejected.
//
// state | meaning
// IDLE  | no transfer in progress, waiting for a setup phase
// WAIT  | access phase, counting down wait states
// RESP  | PREADY high for one cycle; write commits at the end of it
module apb_reg_slave #(
  parameter int                    PDATA_SIZE  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_STATES = 0,
  parameter logic [PDATA_SIZE-1:0] ID_VALUE    = 32'hA2B0_0001
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [PDATA_SIZE-1:0]   PADDR,
  input  logic [PDATA_SIZE-1:0]   PWDATA,
  input  logic [PDATA_SIZE/8-1:0] PSTRB,
  input  logic [2:0]              PPROT,
  output logic [PDATA_SIZE-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int                    IDX_W    = $clog2(NUM_REGS);
  localparam int                    NB       = PDATA_SIZE / 8;
  localparam logic [PDATA_SIZE-1:0] ADDR_END = PDATA_SIZE'(NUM_REGS * 4);
  localparam logic [3:0]            WS       = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    err_q, err_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [PDATA_SIZE-1:0]   prdata_q, prdata_d;
  logic                    enter_resp;
  logic                    wr_en;
  logic [PDATA_SIZE-1:0]   regs_q [NUM_REGS];

  logic [IDX_W-1:0]        setup_idx;
  logic                    setup_err;
  logic                    prot_err;
  logic                    unused_prot;

  // Address decode of the current bus address, captured only in the setup phase
  always_comb begin
    setup_idx = PADDR[IDX_W+1:2];
`ifdef APB_SLV_PROT_EN
    // upper half of a power-of-two map is exactly the index MSB
    prot_err  = ~PPROT[0] & setup_idx[IDX_W-1];
`else
    prot_err  = 1'b0;
`endif
    setup_err = (PADDR >= ADDR_END) || (PADDR[1:0] != 2'b00) ||
                (PWRITE && (setup_idx == '0)) || prot_err;
  end

  // PPROT is partly or wholly ignored depending on the build
  assign unused_prot = ^PPROT;

  // Next-state, counter and registered response generation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    err_d      = err_q;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = '0;
    enter_resp = 1'b0;
    wr_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          idx_d = setup_idx;
          err_d = setup_err;
          cnt_d = WS;
          if (WS == 4'd0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!PSEL) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (PENABLE) begin
          if (cnt_q <= 4'd1) begin
            state_d    = RESP;
            cnt_d      = '0;
            enter_resp = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        wr_en   = PSEL && PENABLE && PWRITE && pready_q && !err_q;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // read data is sampled as PREADY rises so it is stable for the whole RESP cycle
    if (enter_resp) begin
      pready_d  = 1'b1;
      pslverr_d = err_d;
      if (!err_d && !PWRITE) begin
        prdata_d = (idx_d == '0) ? ID_VALUE : regs_q[idx_d];
      end
    end
  end

  // FSM and response registers
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Register file with per-byte-lane write enables
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (PSTRB[b]) begin
          regs_q[idx_q][8*b +: 8] <= PWDATA[8*b +: 8];
        end
      end
    end
  end

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed plus randomized bench for apb_reg_slave: one instance with no wait
// states, one with three; expected responses are queued before each transfer
// and compared once the DUT answers.
module tb_apb_reg_slave;

  localparam logic [31:0] ID = 32'hA2B0_0001;

  logic        clk = 1'b0;
  logic        preset;
  logic        psel0, psel3, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3, pslverr0, pslverr3;

  int checks = 0;
  int errors = 0;

  logic [31:0] m0 [16];
  logic [31:0] m3 [16];

  typedef struct {
    string       tag;
    bit          wr;
    logic [31:0] rd;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  apb_reg_slave #(.WAIT_STATES(0)) dut0 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0));

  apb_reg_slave #(.WAIT_STATES(3)) dut3 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_err(input bit wr, input logic [31:0] a, input logic [2:0] prot);
    logic e;
    e = (a >= 32'd64) || (a[1:0] != 2'b00) || (wr && a[5:2] == 4'd0);
`ifdef APB_SLV_PROT_EN
    if (!prot[0] && a[5:2] >= 4'd8) e = 1'b1;
`else
    if (prot == 3'b111 && 1'b0) e = 1'b1;
`endif
    return e;
  endfunction

  // Drives one transfer starting at the current cycle; returns at posedge+1 of the
  // cycle after completion with the bus idle, so consecutive calls are back-to-back.
  task automatic xfer(input bit d3, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input logic [2:0] prot, output logic [31:0] rd,
                      output logic err, output int lat);
    if (d3) psel3 = 1'b1; else psel0 = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb; pprot = prot;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 1;
    while (!(d3 ? pready3 : pready0) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd  = d3 ? prdata3 : prdata0;
    err = d3 ? pslverr3 : pslverr0;
    @(posedge clk); #1;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
  endtask

  task automatic do_xfer(input bit d3, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input logic [2:0] prot, input string tag,
                         input bit use_exp = 1'b0, input logic [31:0] exp_rd = '0);
    exp_t        e, got;
    logic [31:0] rd, cur;
    logic        err;
    int          lat;
    logic [3:0]  idx;
    idx   = addr[5:2];
    cur   = (idx == 4'd0) ? ID : (d3 ? m3[idx] : m0[idx]);
    e.tag = tag;
    e.wr  = wr;
    e.err = exp_err(wr, addr, prot);
    e.lat = d3 ? 4 : 1;
    e.rd  = use_exp ? exp_rd : ((e.err || wr) ? 32'h0 : cur);
    sb.push_back(e);
    if (wr && !e.err) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) cur[8*b +: 8] = wdata[8*b +: 8];
      end
      if (d3) m3[idx] = cur; else m0[idx] = cur;
    end
    xfer(d3, wr, addr, wdata, strb, prot, rd, err, lat);
    got = sb.pop_front();
    check({got.tag, " lat"}, 32'(lat), 32'(got.lat));
    check({got.tag, " err"}, {31'h0, err}, {31'h0, got.err});
    if (!got.wr) check({got.tag, " rdata"}, rd, got.rd);
  endtask

  initial begin
    logic [31:0] a;
    preset = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    for (int i = 0; i < 16; i++) begin m0[i] = '0; m3[i] = '0; end
    repeat (2) @(posedge clk);
    #1;
    check("rst pready0", {31'h0, pready0}, 32'h0);
    check("rst pslverr0", {31'h0, pslverr0}, 32'h0);
    check("rst prdata0", prdata0, 32'h0);
    check("rst pready3", {31'h0, pready3}, 32'h0);
    check("rst prdata3", prdata3, 32'h0);
    preset = 1'b0;
    @(posedge clk); #1;

    do_xfer(0, 1, 32'h04, 32'h1234_5678, 4'hF, 3'b001, "w0 04");
    do_xfer(0, 0, 32'h04, 32'h0, 4'hF, 3'b001, "r0 04", 1, 32'h1234_5678);

    do_xfer(1, 0, 32'h00, 32'h0, 4'hF, 3'b001, "r3 id", 1, ID);
    do_xfer(1, 1, 32'h00, 32'h5555_AAAA, 4'hF, 3'b001, "w3 id");
    do_xfer(1, 0, 32'h00, 32'h0, 4'hF, 3'b001, "r3 id again", 1, ID);

    do_xfer(0, 1, 32'h08, 32'hFFFF_FFFF, 4'hF, 3'b001, "w0 08 ones");
    do_xfer(0, 1, 32'h08, 32'h0000_0000, 4'b0101, 3'b001, "w0 08 strb");
    do_xfer(0, 0, 32'h08, 32'h0, 4'hF, 3'b001, "r0 08", 1, 32'hFF00_FF00);

    do_xfer(0, 1, 32'h0C, 32'h7777_7777, 4'h0, 3'b001, "w0 0c nostrb");
    do_xfer(0, 0, 32'h0C, 32'h0, 4'hF, 3'b001, "r0 0c");

    do_xfer(0, 0, 32'h40, 32'h0, 4'hF, 3'b001, "r0 40 oob");
    do_xfer(0, 0, 32'h06, 32'h0, 4'hF, 3'b001, "r0 06 misal");
    do_xfer(0, 1, 32'h44, 32'hDEAD_BEEF, 4'hF, 3'b001, "w0 44 oob");
    do_xfer(0, 1, 32'h05, 32'hDEAD_BEEF, 4'hF, 3'b001, "w0 05 misal");
    do_xfer(0, 0, 32'h04, 32'h0, 4'hF, 3'b001, "r0 04 keep", 1, 32'h1234_5678);
    do_xfer(0, 0, 32'h08, 32'h0, 4'hF, 3'b001, "r0 08 keep", 1, 32'hFF00_FF00);

    do_xfer(0, 1, 32'h20, 32'hCAFE_0001, 4'hF, 3'b000, "w0 20 unpriv");
    do_xfer(0, 1, 32'h20, 32'h5A5A_A5A5, 4'hF, 3'b001, "w0 20 priv");
    do_xfer(0, 0, 32'h20, 32'h0, 4'hF, 3'b001, "r0 20 priv", 1, 32'h5A5A_A5A5);
    do_xfer(0, 0, 32'h20, 32'h0, 4'hF, 3'b000, "r0 20 unpriv");

    // PSEL dropped mid-wait: no write, no PREADY
    do_xfer(1, 1, 32'h10, 32'hAAAA_5555, 4'hF, 3'b001, "w3 10");
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h1; pstrb = 4'hF;
    @(posedge clk); #1; penable = 1'b1;
    @(posedge clk); #1; psel3 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    check("abort pready3", {31'h0, pready3}, 32'h0);
    @(posedge clk); #1;
    check("abort pready3 later", {31'h0, pready3}, 32'h0);
    do_xfer(1, 0, 32'h10, 32'h0, 4'hF, 3'b001, "r3 10 keep", 1, 32'hAAAA_5555);

    // reset during a wait cycle of a write
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hDEAD_BEEF; pstrb = 4'hF;
    @(posedge clk); #1; penable = 1'b1; preset = 1'b1;
    @(posedge clk); #1;
    check("rstmid pready3", {31'h0, pready3}, 32'h0);
    preset = 1'b0; psel3 = 1'b0; penable = 1'b0;
    for (int i = 0; i < 16; i++) begin m0[i] = '0; m3[i] = '0; end
    repeat (4) begin
      @(posedge clk); #1;
      check("rstmid pready3 after", {31'h0, pready3}, 32'h0);
    end
    do_xfer(1, 0, 32'h0C, 32'h0, 4'hF, 3'b001, "r3 0c after rst", 1, 32'h0);
    do_xfer(0, 0, 32'h04, 32'h0, 4'hF, 3'b001, "r0 04 after rst", 1, 32'h0);

    for (int n = 0; n < 60; n++) begin
      a = 32'($urandom_range(0, 19)) << 2;
      if ($urandom_range(0, 7) == 0) a = a | 32'h2;
      do_xfer(n >= 48, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
              3'($urandom_range(0, 7)), "rand");
    end
    for (int i = 1; i < 16; i++) begin
      do_xfer(0, 0, 32'(i * 4), 32'h0, 4'hF, 3'b001, "final r0");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
